// File: rtl/tap_pkg.sv
// Shared TAP controller constants: state codes, instruction codes, IR widths/values.
// tap_next is the TMS-driven next-state function of the 16-state TAP FSM.
package tap_pkg;

    localparam int unsigned IR_W    = 4;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UP_DR  = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UP_IR  = 4'hD
    } tap_state_t;

    localparam logic [IR_W-1:0] SCAN_TDR   = 4'h2;
    localparam logic [IR_W-1:0] BYPASS     = 4'hF;
    localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;
    localparam logic [IR_W-1:0] IR_RESET   = 4'hF;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UP_DR  : PAU_DR;
            PAU_DR:  n = tms ? EX2_DR : PAU_DR;
            EX2_DR:  n = tms ? UP_DR  : SH_DR;
            UP_DR:   n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UP_IR  : PAU_IR;
            PAU_IR:  n = tms ? EX2_IR : PAU_IR;
            EX2_IR:  n = tms ? UP_IR  : SH_IR;
            UP_IR:   n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tap_fsm_ctrl_if.sv
// Controller-to-TDR scan chain link: enables and serial data in both directions.
interface tap_fsm_ctrl_if;
    logic shift_en;
    logic capture_en;
    logic update_en;
    logic tdr_tdi;
    logic tdr_tdo;

    modport master (output shift_en, capture_en, update_en, tdr_tdi, input tdr_tdo);
    modport slave  (input shift_en, capture_en, update_en, tdr_tdi, output tdr_tdo);
endinterface

// File: rtl/tap_ir_reg.sv
// Instruction register: capture/shift stage plus the update stage that holds ir_q.
module tap_ir_reg
    import tap_pkg::*;
(
    input  logic            tck,
    input  logic            init,
    input  logic            capture,
    input  logic            shift,
    input  logic            update,
    input  logic            tdi,
    output logic [IR_W-1:0] ir_q,
    output logic            sr_lsb
);

    logic [IR_W-1:0] sr_q;

    // Shift right, TDI enters at the MSB so the LSB leaves first.
    always_ff @(posedge tck) begin
        if (init) begin
            sr_q <= IR_RESET;
            ir_q <= IR_RESET;
        end else begin
            if (capture)
                sr_q <= IR_CAPTURE;
            else if (shift)
                sr_q <= {tdi, sr_q[IR_W-1:1]};
            if (update)
                ir_q <= sr_q;
        end
    end

    assign sr_lsb = sr_q[0];

endmodule

// File: rtl/tap_fsm_ctrl.sv
// TAP controller: TMS-decoded FSM, instruction register, bypass bit and TDO mux.
// TDR enables are decodes of the registered state, qualified by SCAN_TDR.
module tap_fsm_ctrl
    import tap_pkg::*;
(
    input  logic                tck,
    input  logic                reset,
    input  logic                TMS,
    input  logic                TDI,
    tap_fsm_ctrl_if.master      tdr,
    output logic                TDO,
    output logic                tdo_en,
    output logic [IR_W-1:0]     ir_q,
    output logic [STATE_W-1:0]  tap_state
);

    tap_state_t state_q;
    tap_state_t state_d;
    logic       bypass_q;
    logic       scan_sel;
    logic       ir_lsb;
    logic       ir_init;

    assign state_d = tap_next(state_q, TMS);

    always_ff @(posedge tck) begin
        if (reset)
            state_q <= TLR;
        else
            state_q <= state_d;
    end

    // IR returns to BYPASS on reset and on every edge that lands in TLR.
    assign ir_init = reset | (state_d == TLR);

    tap_ir_reg u_ir (
        .tck     (tck),
        .init    (ir_init),
        .capture (state_q == CAP_IR),
        .shift   (state_q == SH_IR),
        .update  (state_q == UP_IR),
        .tdi     (TDI),
        .ir_q    (ir_q),
        .sr_lsb  (ir_lsb)
    );

    assign scan_sel = (ir_q == SCAN_TDR);

    always_ff @(posedge tck) begin
        if (reset)
            bypass_q <= 1'b0;
        else if (!scan_sel) begin
            if (state_q == CAP_DR)
                bypass_q <= 1'b0;
            else if (state_q == SH_DR)
                bypass_q <= TDI;
        end
    end

    assign tdr.capture_en = scan_sel & (state_q == CAP_DR);
    assign tdr.shift_en   = scan_sel & (state_q == SH_DR);
    assign tdr.update_en  = scan_sel & (state_q == UP_DR);
    assign tdr.tdr_tdi    = TDI;

    always_comb begin
        TDO = 1'b0;
        if (state_q == SH_IR)
            TDO = ir_lsb;
        else if (state_q == SH_DR)
            TDO = scan_sel ? tdr.tdr_tdo : bypass_q;
    end

    assign tdo_en    = (state_q == SH_DR) | (state_q == SH_IR);
    assign tap_state = STATE_W'(state_q);

endmodule

// File: tb/tb_tap_fsm_ctrl.sv
// Directed bench for tap_fsm_ctrl: reset, IR load, TDR scan, bypass, pause/resume, reset mid-scan.
module tb_tap_fsm_ctrl;

    logic       tck;
    logic       reset;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic       tdo_en;
    logic [3:0] ir_q;
    logic [3:0] tap_state;

    int vectors;
    int miscompares;

    tap_fsm_ctrl_if tdr_bus ();

    tap_fsm_ctrl dut (
        .tck       (tck),
        .reset     (reset),
        .TMS       (TMS),
        .TDI       (TDI),
        .tdr       (tdr_bus),
        .TDO       (TDO),
        .tdo_en    (tdo_en),
        .ir_q      (ir_q),
        .tap_state (tap_state)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge tck);
        #1;
    endtask

    // From RTI: scan an instruction LSB-first and return to RTI.
    task automatic load_ir(input logic [3:0] ins);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, ins[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        vectors++;
        if (tap_state !== 4'hF) begin miscompares++; $display("FAIL reset_state: got %h want f", tap_state); end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        vectors++;
        if (tap_state !== 4'hF) begin miscompares++; $display("FAIL tlr_state: got %h want f", tap_state); end
        vectors++;
        if (ir_q !== 4'hF) begin miscompares++; $display("FAIL reset_ir: got %h want f", ir_q); end
        vectors++;
        if ({tdr_bus.shift_en, tdr_bus.capture_en, tdr_bus.update_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_enables: got %b want 000",
                     {tdr_bus.shift_en, tdr_bus.capture_en, tdr_bus.update_en});
        end
        vectors++;
        if ({TDO, tdo_en} !== 2'b00) begin miscompares++; $display("FAIL reset_tdo: got %b want 00", {TDO, tdo_en}); end
        tick(1'b0, 1'b0);
        vectors++;
        if (tap_state !== 4'hC) begin miscompares++; $display("FAIL to_rti: got %h want c", tap_state); end
    endtask

    task automatic test_ir_load();
        logic [3:0] cap;
        logic [3:0] ins;
        cap = 4'b0001;
        ins = 4'h2;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        vectors++;
        if ({tap_state, tdo_en} !== {4'hA, 1'b1}) begin
            miscompares++; $display("FAIL shir_entry: got %h/%b want a/1", tap_state, tdo_en);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (TDO !== cap[i]) begin miscompares++; $display("FAIL ir_capture_bit%0d: got %b want %b", i, TDO, cap[i]); end
            tick(i == 3, ins[i]);
        end
        vectors++;
        if (tap_state !== 4'h9) begin miscompares++; $display("FAIL ex1ir: got %h want 9", tap_state); end
        tick(1'b1, 1'b0);
        vectors++;
        if ({tap_state, ir_q} !== {4'hD, 4'hF}) begin
            miscompares++; $display("FAIL upir_hold: got %h/%h want d/f", tap_state, ir_q);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if ({tap_state, ir_q} !== {4'hC, 4'h2}) begin
            miscompares++; $display("FAIL ir_updated: got %h/%h want c/2", tap_state, ir_q);
        end
    endtask

    task automatic test_scan_tdr();
        int n_cap, n_sh, n_up;
        logic tms;
        n_cap = 0; n_sh = 0; n_up = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        // CapDR, 128 x ShDR (last exits), Ex1DR, UpDR
        for (int n = 0; n < 131; n++) begin
            tdr_bus.tdr_tdo = 1'($urandom);
            #1;
            if (tdr_bus.capture_en) n_cap++;
            if (tdr_bus.shift_en)   n_sh++;
            if (tdr_bus.update_en)  n_up++;
            if (tap_state == 4'h2) begin
                vectors++;
                if (TDO !== tdr_bus.tdr_tdo) begin
                    miscompares++; $display("FAIL tdr_tdo_follow cyc%0d: got %b want %b", n, TDO, tdr_bus.tdr_tdo);
                end
            end
            tms = (n == 128) || (n == 129);
            tick(tms, 1'(n));
        end
        vectors++;
        if (n_cap !== 1) begin miscompares++; $display("FAIL capture_count: got %0d want 1", n_cap); end
        vectors++;
        if (n_sh !== 128) begin miscompares++; $display("FAIL shift_count: got %0d want 128", n_sh); end
        vectors++;
        if (n_up !== 1) begin miscompares++; $display("FAIL update_count: got %0d want 1", n_up); end
        vectors++;
        if (tap_state !== 4'hC) begin miscompares++; $display("FAIL scan_end: got %h want c", tap_state); end
    endtask

    task automatic test_bypass();
        logic [3:0] pat;
        logic [3:0] exp;
        pat = 4'b1101;
        exp = 4'b1010;
        load_ir(4'hF);
        vectors++;
        if (ir_q !== 4'hF) begin miscompares++; $display("FAIL bypass_ir: got %h want f", ir_q); end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        vectors++;
        if (tdr_bus.capture_en !== 1'b0) begin miscompares++; $display("FAIL bypass_capture: got %b want 0", tdr_bus.capture_en); end
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({TDO, tdr_bus.shift_en} !== {exp[i], 1'b0}) begin
                miscompares++; $display("FAIL bypass_bit%0d: got %b/%b want %b/0", i, TDO, tdr_bus.shift_en, exp[i]);
            end
            tick(i == 3, pat[i]);
        end
        tick(1'b1, 1'b0);
        vectors++;
        if ({tap_state, tdr_bus.update_en} !== {4'h5, 1'b0}) begin
            miscompares++; $display("FAIL bypass_update: got %h/%b want 5/0", tap_state, tdr_bus.update_en);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_pause_scan();
        int n_cap;
        n_cap = 0;
        load_ir(4'h2);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({tap_state, tdr_bus.shift_en, tdr_bus.capture_en} !== {4'h3, 2'b00}) begin
                miscompares++;
                $display("FAIL pause_cyc%0d: got %h/%b%b want 3/00", i, tap_state, tdr_bus.shift_en, tdr_bus.capture_en);
            end
            tick(i == 9, 1'b0);
        end
        if (tdr_bus.capture_en) n_cap++;
        tick(1'b0, 1'b0);
        if (tdr_bus.capture_en) n_cap++;
        vectors++;
        if ({tap_state, tdr_bus.shift_en} !== {4'h2, 1'b1}) begin
            miscompares++; $display("FAIL pause_resume: got %h/%b want 2/1", tap_state, tdr_bus.shift_en);
        end
        vectors++;
        if (n_cap !== 0) begin miscompares++; $display("FAIL resume_recapture: got %0d want 0", n_cap); end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_pause_bypass();
        load_ir(4'hF);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(i == 9, 1'b0);
        tick(1'b0, 1'b0);
        vectors++;
        if ({tap_state, TDO} !== {4'h2, 1'b1}) begin
            miscompares++; $display("FAIL pause_hold_bit: got %h/%b want 2/1", tap_state, TDO);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if (TDO !== 1'b0) begin miscompares++; $display("FAIL pause_next_bit: got %b want 0", TDO); end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        load_ir(4'h2);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        vectors++;
        if ({tap_state, ir_q} !== {4'hA, 4'h2}) begin
            miscompares++; $display("FAIL mid_shir: got %h/%h want a/2", tap_state, ir_q);
        end
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        vectors++;
        if ({tap_state, ir_q} !== {4'hF, 4'hF}) begin
            miscompares++; $display("FAIL reset_mid_scan: got %h/%h want f/f", tap_state, ir_q);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_tms5();
        load_ir(4'h2);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        vectors++;
        if (tap_state !== 4'h2) begin miscompares++; $display("FAIL tms5_start: got %h want 2", tap_state); end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        vectors++;
        if ({tap_state, ir_q} !== {4'h4, 4'h2}) begin
            miscompares++; $display("FAIL tms5_four: got %h/%h want 4/2", tap_state, ir_q);
        end
        tick(1'b1, 1'b0);
        vectors++;
        if ({tap_state, ir_q} !== {4'hF, 4'hF}) begin
            miscompares++; $display("FAIL tms5_tlr: got %h/%h want f/f", tap_state, ir_q);
        end
        tick(1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        TMS = 1'b1;
        TDI = 1'b0;
        tdr_bus.tdr_tdo = 1'b0;
        test_reset();
        test_ir_load();
        test_scan_tdr();
        test_bypass();
        test_pause_scan();
        test_pause_bypass();
        test_reset_mid_scan();
        test_tms5();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tap_fsm_ctrl.md
Name: tap_fsm_ctrl

Overview:
- IEEE 1149.1/1838-style TAP controller. Sits directly upstream of the TDR scan chain.
- Decodes TMS into the 16-state TAP FSM and holds a 4-bit instruction register.
- Drives the TDR's shift_en/capture_en/update_en, gated by the selected instruction.
- Muxes the TDR's serial output, the bypass bit or the IR onto the die-level TDO.

Parameters:
- IR_W, 4, instruction register width.
- IR_CAPTURE, 4'b0001, value loaded into the IR shift stage in Capture-IR (LSBs 01 per 1149.1).
- IR_RESET, 4'hF, IR value after reset / in Test-Logic-Reset (BYPASS).

Ports:
- tck  in  1  test clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- TMS  in  1  test mode select, sampled on rising tck.
- TDI  in  1  serial test data in.
- tdr_tdo  in  1  serial output of the downstream TDR scan chain.
- shift_en  out  1  to TDR: shift enable.
- capture_en  out  1  to TDR: capture enable.
- update_en  out  1  to TDR: update enable.
- tdr_tdi  out  1  to TDR: serial data in (equals TDI).
- TDO  out  1  serial test data out.
- tdo_en  out  1  high only in Shift-DR / Shift-IR.
- ir_q  out  IR_W  current (updated) instruction.
- tap_state  out  4  current FSM state encoding.

Behaviour:
- One clock domain (tck). Reset is synchronous, active-high, sampled on rising tck.
- Reset: tap_state=TLR (4'hF), ir_q=IR_RESET, IR shift stage=IR_RESET, bypass bit=0.
  - shift_en, capture_en, update_en = 0.
  - TDO=0, tdo_en=0.
- Reset mid-scan: reset wins over TMS. Next state is TLR and a partially shifted IR is discarded.
- State encoding (1149.1 standard): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpIR D.
- Transitions, as TMS=0 / TMS=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - SelIR: CapIR / TLR
  - CapX: ShX / Ex1X
  - ShX: ShX / Ex1X
  - Ex1X: PauX / UpX
  - PauX: PauX / Ex2X
  - Ex2X: ShX / UpX
  - UpX: RTI / SelDR
- TMS=1 for 5 consecutive cycles reaches TLR from any state. Entering TLR forces ir_q=IR_RESET.
- Instructions:
  - 4'h2 SCAN_TDR selects the TDR.
  - 4'hF BYPASS.
  - Every other code behaves as BYPASS.
- TDR enables are combinational decodes of registered state, ANDed with (ir_q==SCAN_TDR):
  - capture_en = (state==CapDR)
  - shift_en = (state==ShDR)
  - update_en = (state==UpDR)
  - The TDR acts on the rising edge that ends that state; no extra latency.
- Bypass bit: loads 0 on the edge leaving CapDR; loads TDI on each edge in ShDR; only when BYPASS is selected.
- IR shift stage:
  - Loads IR_CAPTURE on the edge leaving CapIR.
  - In ShIR, shifts right, TDI into the MSB, LSB out first.
  - On the edge leaving UpIR, ir_q ← shift stage.
  - ir_q is stable at all other times, including Pause-IR.
- TDO (combinational):
  - ShIR: IR shift stage bit 0.
  - ShDR with SCAN_TDR: tdr_tdo.
  - ShDR otherwise: bypass bit.
  - Else 0.
  - tdo_en = ShDR or ShIR.
- Pause states hold all shift registers. Exit2 → Shift resumes without recapture.

Decomposition:
- Package tap_pkg: state localparams (16 codes), IR_W, instruction codes SCAN_TDR/BYPASS, IR_CAPTURE.
- One sub-module, tap_ir_reg: the IR shift stage plus update stage, with capture/shift/update/reset-to-default inputs.
- FSM, bypass bit and TDO mux stay in tap_fsm_ctrl.

Test Plan:
- Reset, then TMS=1 for 3 cycles → tap_state=4'hF, ir_q=4'hF, all enables 0, TDO=0.
- From RTI, TMS sequence 1,1,0,0, then shift 4'h2 LSB-first (TMS=0,0,0,1), then TMS=1,0:
  - Bits out on TDO are 1,0,0,0 (IR_CAPTURE).
  - ir_q=4'h2 only after the UpIR edge.
  - tap_state returns to 4'hC (RTI).
- With SCAN_TDR loaded, TMS 1,0,0, then 128 cycles in ShDR, then 1,1:
  - capture_en high exactly 1 cycle.
  - shift_en high 128 cycles.
  - update_en high exactly 1 cycle.
  - TDO follows tdr_tdo throughout.
- BYPASS selected, shift TDI pattern 1,0,1,1 in ShDR → TDO shows 0,1,0,1 (1-cycle delay); shift_en/capture_en/update_en stay 0.
- Pause-DR for 10 cycles mid-shift, then Ex2DR→ShDR:
  - shift_en=0 during the pause.
  - No capture_en pulse on resume.
  - Shifting continues in bit order.
- Assert reset during ShIR after 2 bits → next cycle tap_state=4'hF, ir_q=4'hF. Separately, TMS=1 ×5 from ShDR → TLR.
